// File: rtl/pulse_checker_if.sv
// Pulse-train bus between a pulse source (master) and pulse_checker (slave).
interface pulse_checker_if #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 8
);
  logic             pulse_in;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic [CNT_W-1:0] width_out;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output pulse_in,
    input  period_out, period_valid, width_out, locked, err, err_cnt
  );

  modport slave (
    input  pulse_in,
    output period_out, period_valid, width_out, locked, err, err_cnt
  );
endinterface

// File: rtl/pulse_checker.sv
// Pulse-train checker: measures period/high width, tracks lock and counts errors.
// Optional PULSE_CHECKER_SYNC_EN adds a 2-flop input synchronizer.
//
// state   | meaning
// IDLE    | waiting for the first rise
// MEASURE | one rise seen, first period being measured
// ACQUIRE | counting consecutive good periods toward lock
// LOCKED  | stream matches PERIOD/WIDTH; violations raise err
module pulse_checker #(
  parameter int PERIOD   = 5,
  parameter int WIDTH    = 1,
  parameter int LOCK_CNT = 3,
  parameter int CNT_W    = 8,
  parameter int ERR_W    = 8
) (
  input  logic          clk,
  input  logic          reset,
  pulse_checker_if.slave pc
);

  typedef enum logic [1:0] {IDLE, MEASURE, ACQUIRE, LOCKED} state_e;

  localparam logic [CNT_W-1:0] PER_C   = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] WID_C   = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] TO_C    = CNT_W'(2 * PERIOD);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  localparam logic [3:0]       LOCK_C  = 4'(LOCK_CNT);

  logic pin;

`ifdef PULSE_CHECKER_SYNC_EN
  logic s1_q, s1_d, s2_q, s2_d;

  always_comb begin
    s1_d = pc.pulse_in;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign pin = s2_q;
`else
  assign pin = pc.pulse_in;
`endif

  state_e           state_q, state_d;
  logic             p_q, p_d;
  logic [CNT_W-1:0] g_q, g_d, h_q, h_d;
  logic [3:0]       good_q, good_d;
  logic [CNT_W-1:0] period_q, period_d, width_q, width_d;
  logic             pv_q, pv_d, locked_q, locked_d, err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic rise, fall, timeout, period_good, width_good;

  assign rise        = pin & ~p_q;
  assign fall        = ~pin & p_q;
  assign timeout     = (g_q == TO_C) & ~rise;
  assign period_good = (g_q == PER_C);
  assign width_good  = (h_q == WID_C);

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    period_d = period_q;
    width_d  = width_q;
    pv_d     = 1'b0;
    err_d    = 1'b0;
    p_d      = pin;

    g_d = rise ? CNT_W'(1) : (g_q == CNT_MAX) ? g_q : g_q + CNT_W'(1);
    h_d = rise ? CNT_W'(1) : (pin && h_q != CNT_MAX) ? h_q + CNT_W'(1) : h_q;

    if (rise && state_q != IDLE) begin
      period_d = g_q;
      pv_d     = 1'b1;
    end
    if (fall) width_d = h_q;

    // Timeout takes priority over a width check landing on the same edge.
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MEASURE;
          good_d  = 4'd0;
        end
      end
      MEASURE: begin
        if (rise) begin
          good_d  = period_good ? 4'd1 : 4'd0;
          state_d = (period_good && LOCK_C == 4'd1) ? LOCKED : ACQUIRE;
        end else if (timeout) begin
          state_d = IDLE;
          good_d  = 4'd0;
        end
      end
      ACQUIRE: begin
        if (rise) begin
          if (period_good) begin
            good_d = good_q + 4'd1;
            if (good_q + 4'd1 == LOCK_C) state_d = LOCKED;
          end else begin
            good_d = 4'd0;
          end
        end else if (timeout) begin
          state_d = IDLE;
          good_d  = 4'd0;
        end else if (fall && !width_good) begin
          good_d = 4'd0;
        end
      end
      LOCKED: begin
        if (rise && !period_good) begin
          err_d   = 1'b1;
          state_d = ACQUIRE;
          good_d  = 4'd0;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
          good_d  = 4'd0;
        end else if (fall && !width_good) begin
          err_d   = 1'b1;
          state_d = ACQUIRE;
          good_d  = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    locked_d  = (state_d == LOCKED);
    err_cnt_d = (err_d && err_cnt_q != ERR_MAX) ? err_cnt_q + ERR_W'(1) : err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      p_q       <= 1'b0;
      g_q       <= '0;
      h_q       <= '0;
      good_q    <= 4'd0;
      period_q  <= '0;
      width_q   <= '0;
      pv_q      <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      g_q       <= g_d;
      h_q       <= h_d;
      good_q    <= good_d;
      period_q  <= period_d;
      width_q   <= width_d;
      pv_q      <= pv_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign pc.period_out   = period_q;
  assign pc.period_valid = pv_q;
  assign pc.width_out    = width_q;
  assign pc.locked       = locked_q;
  assign pc.err          = err_q;
  assign pc.err_cnt      = err_cnt_q;

endmodule
